// File: rtl/sfp_addsub_pipe.sv
// sfp_addsub_pipe: N_CH-lane signed fixed-point add/sub, resized to the output format.
// Resize clips or wraps integer overflow and floors dropped fraction bits; valid/ready handshake with no bubbles.
module sfp_addsub_pipe #(
    parameter int N_CH = 4,
    parameter int IW1  = 8,
    parameter int QW1  = 8,
    parameter int IW2  = 8,
    parameter int QW2  = 8,
    parameter int IWO  = 8,
    parameter int QWO  = 8,
    parameter int CLIP = 1,
    parameter int PIPE = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sub,
    input  logic [N_CH*(IW1+QW1)-1:0]    in1,
    input  logic [N_CH*(IW2+QW2)-1:0]    in2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_CH*(IWO+QWO)-1:0]    out,
    output logic [N_CH-1:0]              out_clip,
    output logic [N_CH-1:0]              clip_stky,
    input  logic                         clr_stky
);
    localparam int W1  = IW1 + QW1;
    localparam int W2  = IW2 + QW2;
    localparam int WO  = IWO + QWO;
    localparam int IWF = ((IW1 > IW2) ? IW1 : IW2) + 1;
    localparam int QWF = (QW1 > QW2) ? QW1 : QW2;
    localparam int WF  = IWF + QWF;
    localparam int QWX = (QWF > QWO) ? QWF : QWO;
    localparam int IWM = (IWF > IWO) ? IWF : IWO;
    localparam int WE  = IWM + QWX;
    localparam int WM  = IWM + QWO;
    localparam int NT  = WM - WO + 1;

    function automatic logic signed [WF-1:0] addsub(input logic signed [W1-1:0] a,
                                                    input logic signed [W2-1:0] b,
                                                    input logic sub);
        logic signed [WF-1:0] ax;
        logic signed [WF-1:0] bx;
        ax = WF'(a) <<< (QWF - QW1);
        bx = WF'(b) <<< (QWF - QW2);
        return sub ? (ax - bx) : (ax + bx);
    endfunction

    // Returns {clip_flag, resized_value}. Working width covers both formats so one path handles every case.
    function automatic logic [WO:0] resize(input logic signed [WF-1:0] s);
        logic signed [WE-1:0] e;
        logic signed [WM-1:0] t;
        logic [NT-1:0]        top;
        logic [WO-1:0]        r;
        logic                 ovf;
        e   = WE'(s) <<< (QWX - QWF);
        t   = WM'(e >>> (QWX - QWO));
        top = t[WM-1:WO-1];
        ovf = (top != '0) && (top != '1);
        r   = t[WO-1:0];
        if (ovf && (CLIP != 0))
            r = t[WM-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
        return {ovf, r};
    endfunction

    logic signed [WF-1:0] sum_p0 [N_CH];
    logic signed [WF-1:0] o_src  [N_CH];
    logic                 o_src_vld;
    logic                 ld_o;
    logic [WO:0]          res    [N_CH];

    logic                 out_vld_q, out_vld_d;
    logic [N_CH*WO-1:0]   out_q, out_d;
    logic [N_CH-1:0]      clip_q, clip_d;
    logic [N_CH-1:0]      stky_q, stky_d;

    always_comb begin
        for (int k = 0; k < N_CH; k++)
            sum_p0[k] = addsub(in1[k*W1 +: W1], in2[k*W2 +: W2], in_sub);
    end

    assign ld_o = ~out_vld_q | out_ready;

    generate
        if (PIPE >= 2) begin : g_p2
            logic                 vld_p1_q, vld_p1_d;
            logic signed [WF-1:0] sum_p1_q [N_CH];
            logic signed [WF-1:0] sum_p1_d [N_CH];
            logic                 ld_p1;

            // Stage p1: full-precision sum
            assign ld_p1    = ~vld_p1_q | ld_o;
            assign in_ready = ld_p1;

            always_comb begin
                vld_p1_d = ld_p1 ? in_valid : vld_p1_q;
                for (int k = 0; k < N_CH; k++)
                    sum_p1_d[k] = (ld_p1 && in_valid) ? sum_p0[k] : sum_p1_q[k];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vld_p1_q <= 1'b0;
                else        vld_p1_q <= vld_p1_d;
            end

            always_ff @(posedge clk) begin
                sum_p1_q <= sum_p1_d;
            end

            assign o_src_vld = vld_p1_q;
            assign o_src     = sum_p1_q;
        end else begin : g_p1
            assign in_ready  = ld_o;
            assign o_src_vld = in_valid;
            assign o_src     = sum_p0;
        end
    endgenerate

    // Output stage: resized result, clip flags and sticky flags
    always_comb begin
        out_vld_d = ld_o ? o_src_vld : out_vld_q;
        out_d     = out_q;
        clip_d    = clip_q;
        for (int k = 0; k < N_CH; k++) begin
            res[k] = resize(o_src[k]);
            if (ld_o && o_src_vld) begin
                out_d[k*WO +: WO] = res[k][WO-1:0];
                clip_d[k]         = res[k][WO];
            end
        end
        stky_d = (clr_stky ? '0 : stky_q) | ((out_vld_q && out_ready) ? clip_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            clip_q    <= '0;
            stky_q    <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            clip_q    <= clip_d;
            stky_q    <= stky_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out       = out_q;
    assign out_clip  = clip_q;
    assign clip_stky = stky_q;
endmodule
